// File: rtl/ipg_pkg.sv
// rtl/ipg_pkg.sv - shared constants, state type and block-type decode for the IPG transmit scheduler
package ipg_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Frame-opening control block types
  localparam logic [7:0] BLOCK_TYPE_S0   = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_S4   = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_S4_O = 8'h66;

  // Frame-closing control block types
  localparam logic [7:0] BLOCK_TYPE_T0 = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_T1 = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_T2 = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_T3 = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_T4 = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_T5 = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_T6 = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_T7 = 8'hff;

  // Slot select towards the slicer
  localparam logic [1:0] TUSER_NET  = 2'b00;
  localparam logic [1:0] TUSER_IPG  = 2'b01;
  localparam logic [1:0] TUSER_IDLE = 2'b10;

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_INJECT = 2'd1,
    ST_HOLD   = 2'd2
  } sched_state_t;

  function automatic logic is_start(input logic [7:0] blk_type);
    logic hit;
    hit = 1'b0;
    case (blk_type)
      BLOCK_TYPE_S0, BLOCK_TYPE_S4, BLOCK_TYPE_S4_O: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_term(input logic [7:0] blk_type);
    logic hit;
    hit = 1'b0;
    case (blk_type)
      BLOCK_TYPE_T0, BLOCK_TYPE_T1, BLOCK_TYPE_T2, BLOCK_TYPE_T3,
      BLOCK_TYPE_T4, BLOCK_TYPE_T5, BLOCK_TYPE_T6, BLOCK_TYPE_T7: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/frame_tracker.sv
// rtl/frame_tracker.sv - open/closed Ethernet frame flag derived from popped network blocks
module frame_tracker
  import ipg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_take,
  input  logic [1:0] blk_hdr,
  input  logic [7:0] blk_type,
  output logic       in_frame,
  output logic       in_frame_next
);

  logic in_frame_q;
  logic in_frame_d;

  // Terminate is checked first so a block that looks like both closes the frame
  always_comb begin
    in_frame_d = in_frame_q;
    if (blk_take) begin
      if (is_term(blk_type)) begin
        in_frame_d = 1'b0;
      end else if ((blk_hdr == SYNC_CTRL) && is_start(blk_type)) begin
        in_frame_d = 1'b1;
      end
    end
  end

  // Frame flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_frame_q <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
    end
  end

  assign in_frame      = in_frame_q;
  assign in_frame_next = in_frame_d;

endmodule

// File: rtl/ipg_tx_sched.sv
// rtl/ipg_tx_sched.sv - shares the PCS block slot between netq blocks and IPG message blocks
module ipg_tx_sched
  import ipg_pkg::*;
#(
  parameter int NETQ_DEPTH = 4,
  parameter int MAX_INJECT = 8,
  parameter int NETQ_HI    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          netq_empty,
  input  logic [$clog2(NETQ_DEPTH):0]   netq_level,
  input  logic [1:0]                    netq_hdr_head,
  input  logic [7:0]                    netq_type_head,
  input  logic                          memq_empty,
  input  logic                          msg_done,
  output logic                          netq_read,
  output logic                          memq_read,
  output logic                          ipg_en,
  output logic [1:0]                    tuser,
  output logic                          in_frame,
  output logic [31:0]                   inject_total,
  output logic [15:0]                   yield_total
);

  localparam int LVL_W = $clog2(NETQ_DEPTH) + 1;
  localparam logic [7:0]       LAST_CNT = 8'(MAX_INJECT - 1);
  localparam logic [LVL_W-1:0] HI_LVL   = LVL_W'(NETQ_HI);

  sched_state_t state_q, state_d;
  logic         ipg_en_q, ipg_en_d;
  logic [1:0]   tuser_q, tuser_d;
  logic [7:0]   inject_cnt_q, inject_cnt_d;
  logic [31:0]  inject_total_q, inject_total_d;
  logic [15:0]  yield_total_q, yield_total_d;

  logic in_frame_next;
  logic head_is_start;
  logic guard;

  frame_tracker u_frame_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .blk_take      (netq_read),
    .blk_hdr       (netq_hdr_head),
    .blk_type      (netq_type_head),
    .in_frame      (in_frame),
    .in_frame_next (in_frame_next)
  );

  assign head_is_start = (netq_hdr_head == SYNC_CTRL) && is_start(netq_type_head);
  assign guard         = (inject_cnt_q == LAST_CNT) || (netq_level >= HI_LVL);

  // Queue pop strobes: combinational from state and inputs, held low in reset
  always_comb begin
    netq_read = 1'b0;
    memq_read = 1'b0;
    if (rst_n) begin
      if (state_q == ST_INJECT) begin
        memq_read = msg_done;
      end else begin
        netq_read = !netq_empty;
      end
    end
  end

  // Next-state and counter logic; in_frame_next lets a gap open in the cycle the terminate is popped.
  // In the msg_done cycle memq_empty reports whether another message is queued behind the one finishing.
  always_comb begin
    state_d        = state_q;
    inject_cnt_d   = inject_cnt_q;
    inject_total_d = inject_total_q;
    yield_total_d  = yield_total_q;
    case (state_q)
      ST_PASS: begin
        if (!in_frame_next && !memq_empty && (netq_empty || !head_is_start)) begin
          state_d      = ST_INJECT;
          inject_cnt_d = 8'd0;
        end
      end
      ST_INJECT: begin
        inject_cnt_d = inject_cnt_q + 8'd1;
        if (inject_total_q != 32'hffff_ffff) begin
          inject_total_d = inject_total_q + 32'd1;
        end
        if (msg_done) begin
          if (guard || memq_empty) begin
            state_d = ST_PASS;
          end
        end else if (guard) begin
          state_d = ST_HOLD;
          if (yield_total_q != 16'hffff) begin
            yield_total_d = yield_total_q + 16'd1;
          end
        end
      end
      ST_HOLD: begin
        if (netq_empty && !in_frame) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
    ipg_en_d = (state_d == ST_INJECT);
    if (state_d == ST_INJECT) begin
      tuser_d = TUSER_IPG;
    end else if (netq_read) begin
      tuser_d = TUSER_NET;
    end else begin
      tuser_d = TUSER_IDLE;
    end
  end

  // Scheduler state, slot selects and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_PASS;
      ipg_en_q       <= 1'b0;
      tuser_q        <= TUSER_IDLE;
      inject_cnt_q   <= 8'd0;
      inject_total_q <= 32'd0;
      yield_total_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      ipg_en_q       <= ipg_en_d;
      tuser_q        <= tuser_d;
      inject_cnt_q   <= inject_cnt_d;
      inject_total_q <= inject_total_d;
      yield_total_q  <= yield_total_d;
    end
  end

  assign ipg_en       = ipg_en_q;
  assign tuser        = tuser_q;
  assign inject_total = inject_total_q;
  assign yield_total  = yield_total_q;

endmodule

// File: tb/tb_ipg_tx_sched.sv
// tb/tb_ipg_tx_sched.sv - scoreboard bench for ipg_tx_sched against a slot-level reference model
module tb_ipg_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        netq_empty = 1'b1;
  logic [2:0]  netq_level = 3'd0;
  logic [1:0]  netq_hdr_head = 2'b00;
  logic [7:0]  netq_type_head = 8'h00;
  logic        memq_empty = 1'b1;
  logic        msg_done = 1'b0;
  logic        netq_read, memq_read, ipg_en, in_frame;
  logic [1:0]  tuser;
  logic [31:0] inject_total;
  logic [15:0] yield_total;

  always #5 clk = ~clk;

  ipg_tx_sched #(.NETQ_DEPTH(4), .MAX_INJECT(8), .NETQ_HI(3)) dut (
    .clk(clk), .rst_n(rst_n), .netq_empty(netq_empty), .netq_level(netq_level),
    .netq_hdr_head(netq_hdr_head), .netq_type_head(netq_type_head),
    .memq_empty(memq_empty), .msg_done(msg_done), .netq_read(netq_read),
    .memq_read(memq_read), .ipg_en(ipg_en), .tuser(tuser), .in_frame(in_frame),
    .inject_total(inject_total), .yield_total(yield_total)
  );

  typedef struct {
    logic        nr;
    logic        mr;
    logic        ie;
    logic [1:0]  tu;
    logic        inf;
    logic [31:0] it;
    logic [15:0] yt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Environment: netq contents {hdr,type}, pending message lengths, slicer progress
  logic [9:0] netq[$];
  int         msg_len[$];
  int         prog = 0;

  // Reference model: slot owner 0=network, 1=IPG burst, 2=yielded
  int          mode = 0;
  bit          m_in_frame = 0;
  bit          m_ipg = 0;
  logic [1:0]  m_tuser = 2'b10;
  int          m_burst = 0;
  longint      m_itot = 0;
  int          m_ytot = 0;

  function automatic bit blk_start(input logic [9:0] b);
    return (b[9:8] == 2'b01) && (b[7:0] == 8'h78 || b[7:0] == 8'h33 || b[7:0] == 8'h66);
  endfunction

  function automatic bit blk_term(input logic [7:0] t);
    return t == 8'h87 || t == 8'h99 || t == 8'haa || t == 8'hb4 ||
           t == 8'hcc || t == 8'hd2 || t == 8'he1 || t == 8'hff;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("netq_read", 32'(netq_read), 32'(mon_e.nr));
      chk("memq_read", 32'(memq_read), 32'(mon_e.mr));
      chk("ipg_en", 32'(ipg_en), 32'(mon_e.ie));
      chk("tuser", 32'(tuser), 32'(mon_e.tu));
      chk("in_frame", 32'(in_frame), 32'(mon_e.inf));
      chk("inject_total", inject_total, mon_e.it);
      chk("yield_total", 32'(yield_total), 32'(mon_e.yt));
    end
  end

  // One clock of stimulus: drive inputs, predict this cycle, advance the model
  task automatic step(input bit rst_v);
    bit         done, nr, mr, emp, f_next, guard;
    logic [9:0] head;
    exp_t       e;
    int         nxt;
    @(posedge clk);
    #1;
    head = (netq.size() > 0) ? netq[0] : 10'h000;
    done = rst_v && (mode == 1) && (msg_len.size() > 0) && (prog + 1 >= msg_len[0]);
    emp  = done ? (msg_len.size() <= 1) : (msg_len.size() == 0);
    rst_n          = rst_v;
    netq_empty     = (netq.size() == 0);
    netq_level     = 3'(netq.size());
    netq_hdr_head  = head[9:8];
    netq_type_head = head[7:0];
    memq_empty     = emp;
    msg_done       = done;
    nr = rst_v && (mode != 1) && (netq.size() > 0);
    mr = done;
    e.nr = nr; e.mr = mr; e.ie = m_ipg; e.tu = m_tuser; e.inf = m_in_frame;
    e.it = m_itot[31:0]; e.yt = 16'(m_ytot);
    exp_q.push_back(e);
    if (!rst_v) begin
      mode = 0; m_in_frame = 0; m_ipg = 0; m_tuser = 2'b10;
      m_burst = 0; m_itot = 0; m_ytot = 0; prog = 0;
    end else begin
      f_next = m_in_frame;
      if (nr) begin
        if (blk_term(head[7:0])) f_next = 0;
        else if (blk_start(head)) f_next = 1;
      end
      nxt = mode;
      if (mode == 0) begin
        if (!f_next && !emp && (netq.size() == 0 || !blk_start(head))) begin
          nxt = 1;
          m_burst = 0;
        end
      end else if (mode == 1) begin
        guard = (m_burst == 7) || (netq.size() >= 3);
        if (m_itot < 64'hffff_ffff) m_itot++;
        prog++;
        m_burst++;
        if (done) begin
          void'(msg_len.pop_front());
          prog = 0;
          if (guard || emp) nxt = 0;
        end else if (guard) begin
          nxt = 2;
          if (m_ytot < 16'hffff) m_ytot++;
        end
      end else begin
        if (netq.size() == 0 && !m_in_frame) nxt = 0;
      end
      mode = nxt;
      m_ipg = (nxt == 1);
      m_tuser = (nxt == 1) ? 2'b01 : (nr ? 2'b00 : 2'b10);
      m_in_frame = f_next;
    end
    if (nr) void'(netq.pop_front());
  endtask

  task automatic wait_burst();
    for (int i = 0; i < 200 && mode != 1; i++) step(1);
    if (mode != 1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_burst: got mode %0d, expected 1 within 200 cycles", mode);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && !(msg_len.size() == 0 && netq.size() == 0 && mode == 0); i++) step(1);
    if (!(msg_len.size() == 0 && netq.size() == 0 && mode == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got mode %0d msgs %0d, expected idle within 1000 cycles", mode, msg_len.size());
    end
  endtask

  function automatic logic [9:0] rand_blk();
    int r;
    logic [7:0] st[3];
    logic [7:0] tm[8];
    st = '{8'h78, 8'h33, 8'h66};
    tm = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
    r = $urandom_range(0, 9);
    if (r == 0) return {2'b01, st[$urandom_range(0, 2)]};
    if (r == 1) return {2'b01, tm[$urandom_range(0, 7)]};
    if (r == 2) return {2'b01, 8'h1e};
    return {2'b10, 8'($urandom)};
  endfunction

  initial begin
    // Reset with two data blocks waiting, then release
    netq.push_back({2'b10, 8'h11});
    netq.push_back({2'b10, 8'h22});
    repeat (3) step(0);
    repeat (5) step(1);

    // Start / data / terminate with a message pending throughout
    netq.push_back({2'b01, 8'h78});
    netq.push_back({2'b10, 8'h55});
    netq.push_back({2'b01, 8'h87});
    msg_len.push_back(3);
    repeat (10) step(1);

    // Five-block message on an idle line
    msg_len.push_back(5);
    repeat (10) step(1);

    // Long message: burst budget exhausts, yields, resumes
    msg_len.push_back(20);
    repeat (40) step(1);
    drain();

    // netq fills to the high mark mid-burst
    msg_len.push_back(30);
    wait_burst();
    for (int i = 0; i < 3; i++) begin
      step(1);
      netq.push_back({2'b10, 8'(i + 8'h40)});
    end
    repeat (6) step(1);

    // Reset in the middle of a burst
    wait_burst();
    repeat (2) step(1);
    repeat (2) step(0);
    drain();

    // Message completion coincides with netq reaching the high mark
    msg_len.push_back(4);
    wait_burst();
    for (int i = 0; i < 3; i++) begin
      step(1);
      netq.push_back({2'b10, 8'(i + 8'h60)});
    end
    repeat (8) step(1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0 && netq.size() < 4) netq.push_back(rand_blk());
      if ($urandom_range(0, 15) == 0 && msg_len.size() < 3) msg_len.push_back($urandom_range(1, 12));
      step($urandom_range(0, 299) != 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ipg_tx_sched.md
# ipg_tx_sched

Transmit-side scheduler that shares the 66b PCS block slot between buffered network blocks (`netq`) and IPG message blocks drawn from the message queue (`memq`). It replaces the simple buffer monitor. It tracks Ethernet frame boundaries from the network block stream and injects IPG control blocks only between frames. Injection is bounded by a block budget and by network-queue back-pressure. It drives the queue read strobes and the `ipg_en`/`tuser` selects consumed by the IPG slicer datapath.

## Interface
Parameters:
- `NETQ_DEPTH`, 4: netq depth in blocks; width of `netq_level` is `$clog2(NETQ_DEPTH)+1`.
- `MAX_INJECT`, 8: maximum consecutive IPG blocks per injection burst (1..255).
- `NETQ_HI`, 3: netq fill level at or above which an active burst yields.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `netq_empty` in 1: netq has no block.
- `netq_level` in 3: netq occupancy in blocks.
- `netq_hdr_head` in 2: sync header of the netq head block (2'b10 data, 2'b01 ctrl).
- `netq_type_head` in 8: bits [7:0] of the netq head block (block type).
- `memq_empty` in 1: no IPG message pending.
- `msg_done` in 1: the slicer emitted the last bits of the current message this cycle.
- `netq_read` out 1: pop the netq head this cycle.
- `memq_read` out 1: pop the finished message.
- `ipg_en` out 1: the slicer outputs an IPG control block this cycle.
- `tuser` out 2: 00 network block, 01 IPG block, 10 idle filler, 11 unused.
- `in_frame` out 1: the current network frame is open.
- `inject_total` out 32: count of IPG blocks sent, saturating.
- `yield_total` out 16: count of bursts ended by the guard, saturating.

## Operation
- States: PASS, INJECT, HOLD.
- Frame tracking:
  - On `netq_read` with `netq_hdr_head`=01 and type in {0x78, 0x33, 0x66}: set `in_frame`.
  - On `netq_read` with type in {0x87, 0x99, 0xaa, 0xb4, 0xcc, 0xd2, 0xe1, 0xff}: clear `in_frame`.
  - Start and terminate in one block (not legal) resolve to clear.
- PASS:
  - `netq_read` = !`netq_empty`.
  - `tuser` = 00 if reading, else 10.
  - Transition to INJECT when !`in_frame` & !`memq_empty` & (`netq_empty` | head is not a start block).
- INJECT:
  - `netq_read`=0; netq buffers incoming blocks.
  - `ipg_en`=1, `tuser`=01, `inject_cnt` increments.
  - `msg_done` → `memq_read`=1 in the same cycle. Then go to PASS if `memq_empty` is asserted next, or if the next message is absent; otherwise stay and continue with the next message.
  - Guard: `inject_cnt`==`MAX_INJECT`-1 or `netq_level`>=`NETQ_HI` → HOLD, increment `yield_total`. The message is not popped; the slicer keeps its partial count and resumes later.
- HOLD:
  - Behaves as PASS.
  - No injection until `netq_empty` is asserted for one cycle while !`in_frame`, then go to PASS.
- `msg_done` together with the guard: the pop wins (`memq_read`=1), `yield_total` is not incremented, next state is PASS.
- `inject_cnt` clears on every entry to INJECT.
- `inject_total` and `yield_total` saturate at all-ones.

## Timing
- State, `in_frame`, `ipg_en`, `tuser`, `inject_cnt` and counters are registered. `netq_read` and `memq_read` are combinational from state and inputs, with no other combinational path.
- Entry into INJECT takes effect the cycle after the condition holds. The first IPG block is in that cycle.
- Exit: the guard is seen in cycle N; the last IPG block is N; network output resumes at N+1.
- Reset values: state=PASS, `in_frame`=0, `ipg_en`=0, `tuser`=10, `netq_read`=0, `memq_read`=0, counters=0.
  - Reset mid-burst discards the burst. The partial message is not popped.
  - Strobes are forced to 0 while `rst_n`=0.
- Simultaneous start-block arrival and a pending message in PASS: the network block is sent; injection is deferred.

## Structure
- Shared package `ipg_pkg`:
  - `SYNC_DATA` and `SYNC_CTRL`.
  - All `BLOCK_TYPE_*` constants.
  - The `tuser` encoding.
  - State enum `sched_state_t`.
  - Functions `is_start(type)` and `is_term(type)`.
- One natural sub-module: `frame_tracker`, which contains the `in_frame` flag and the start/terminate decode.

## Test plan
- Reset, then release with netq holding 2 data blocks and memq empty → `tuser`=00 for 2 cycles then 10; `in_frame`=0; counters 0.
- Frame 0x78, data, 0x87 with a message pending throughout → no `ipg_en` until the cycle after the 0x87 read; `in_frame` rises after the 0x78 read and falls after the 0x87 read.
- Message pending, netq empty, `msg_done` after 5 IPG blocks → `memq_read` for 1 cycle, `inject_total`=5, state PASS.
- `MAX_INJECT`=8, message never done → 8 IPG blocks, HOLD, `yield_total`=1, no `memq_read`; resumes only after netq drains.
- During INJECT, `netq_level` steps to 3 → `ipg_en` drops next cycle, `netq_read`=1.
- `msg_done` and `netq_level`=3 in the same cycle → `memq_read`=1, `yield_total` unchanged; reset asserted in INJECT → reset values on the next edge.
